cordic_quad_prerot: RTL and testbench

//  Quadrant pre-rotation stage that sits directly upstream of the CORDIC core.
//  It folds full-circle requests into the core's convergence range (|angle| <= pi/2):
//   - rotation mode: |z| > pi/2
//   - vectoring mode: x < 0
//  A fold negates x and y and shifts z by pi. The result is presented on a

---
 rtl/cordic_quad_prerot.sv | 193 +++++++++++++++++++
 tb/tb_cordic_quad_prerot.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_quad_prerot.sv
// -----------------------------------------------------------------------------
// cordic_quad_prerot
//
// Quadrant pre-rotation stage in front of the CORDIC core. Requests whose
// angle lies outside the core's convergence range (|angle| <= pi/2) are folded
// by pi so the core only ever sees convergent inputs:
//   - rotation mode  (mode_in = 0): fold when z lies in [pi/2, pi) or [-pi, -pi/2)
//   - vectoring mode (mode_in = 1): fold when x < 0
// A fold negates x and y (saturating the most-negative value) and adds pi to z
// (MSB inversion of the binary angle). flip_out tells downstream that the
// sample was folded.
//
// The folded sample is registered into a 2-entry skid buffer. This gives one
// sample per cycle of throughput while in_ready comes straight from a flop and
// has no combinational path from out_ready.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        upstream sample valid
//   in_ready   out  1        stage can accept a sample this cycle (registered)
//   mode_in    in   1        0 = rotation, 1 = vectoring
//   x_in       in   XY_W     signed x
//   y_in       in   XY_W     signed y
//   z_in       in   ANGLE_W  signed binary angle (2^(ANGLE_W-1) LSB = pi)
//   out_valid  out  1        folded sample valid
//   out_ready  in   1        downstream (core) ready
//   mode_out   out  1        mode travelling with the sample
//   x_out      out  XY_W     folded x
//   y_out      out  XY_W     folded y
//   z_out      out  ANGLE_W  folded z
//   flip_out   out  1        1 = sample was folded by pi
// -----------------------------------------------------------------------------
module cordic_quad_prerot #(
    parameter int XY_W    = 16,
    parameter int ANGLE_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode_in,
    input  logic [XY_W-1:0]    x_in,
    input  logic [XY_W-1:0]    y_in,
    input  logic [ANGLE_W-1:0] z_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               mode_out,
    output logic [XY_W-1:0]    x_out,
    output logic [XY_W-1:0]    y_out,
    output logic [ANGLE_W-1:0] z_out,
    output logic               flip_out
);

    typedef struct packed {
        logic               mode;
        logic               flip;
        logic [XY_W-1:0]    x;
        logic [XY_W-1:0]    y;
        logic [ANGLE_W-1:0] z;
    } sample_t;

    // EMPTY: nothing held. ONE: main holds a sample. FULL: main and skid both hold.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [XY_W-1:0] XY_MIN = {1'b1, {(XY_W-1){1'b0}}};
    localparam logic [XY_W-1:0] XY_MAX = {1'b0, {(XY_W-1){1'b1}}};

    // Two's-complement negation; -MIN is not representable, so clamp to MAX.
    function automatic logic [XY_W-1:0] neg_sat(input logic [XY_W-1:0] v);
        if (v == XY_MIN) begin
            return XY_MAX;
        end
        return -v;
    endfunction

    state_t  state_q, state_d;
    sample_t main_q, skid_q;
    sample_t in_sample;
    logic    in_ready_q;
    logic    fold;
    logic    accept, pop;
    logic    load_main_in, load_main_skid, load_skid;

    // ------------------------------------------------------------------------
    // Fold decision and arithmetic on the input side
    // ------------------------------------------------------------------------
    // NOTE: combinational blocks use blocking (=) assignments and give every
    // output a value on every path, so no latch can be inferred.
    always_comb begin
        // Top two angle bits differing means the angle is in the left half-plane;
        // -pi/2 (bits 11) is inside the convergence range and stays put.
        fold = mode_in ? x_in[XY_W-1] : (z_in[ANGLE_W-1] ^ z_in[ANGLE_W-2]);

        in_sample.mode = mode_in;
        in_sample.flip = fold;
        in_sample.x    = fold ? neg_sat(x_in) : x_in;
        in_sample.y    = fold ? neg_sat(y_in) : y_in;
        // Adding pi to a binary angle only toggles the MSB; wrap is intended.
        in_sample.z    = {z_in[ANGLE_W-1] ^ fold, z_in[ANGLE_W-2:0]};
    end

    // ------------------------------------------------------------------------
    // Skid-buffer control
    // ------------------------------------------------------------------------
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    load_main_in = 1'b1;
                    state_d      = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    // Main drains and refills in the same cycle: no bubble.
                    load_main_in = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_d   = ST_FULL;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a pop can happen.
                if (pop) begin
                    load_main_skid = 1'b1;
                    state_d        = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking (<=) assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            // in_ready reflects "skid entry free" one cycle ahead, so it stays
            // a plain flop and ignores out_ready combinationally.
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    // NOTE: the data registers are reset as well, because the outputs are
    // required to read zero during reset rather than stale samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_sample;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_sample;
            end
        end
    end

    assign in_ready = in_ready_q;
    assign mode_out = main_q.mode;
    assign flip_out = main_q.flip;
    assign x_out    = main_q.x;
    assign y_out    = main_q.y;
    assign z_out    = main_q.z;

endmodule

// File: tb/tb_cordic_quad_prerot.sv
// -----------------------------------------------------------------------------
// tb_cordic_quad_prerot
//
// Directed testbench for cordic_quad_prerot (XY_W = 16, ANGLE_W = 32).
// Inputs change 1 time unit after the rising edge; outputs are read at the
// same point, where they are stable until the next edge.
// -----------------------------------------------------------------------------
module tb_cordic_quad_prerot;

    localparam int XY_W    = 16;
    localparam int ANGLE_W = 32;

    typedef struct packed {
        logic        mode;
        logic        flip;
        logic [15:0] x;
        logic [15:0] y;
        logic [31:0] z;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic               mode_in;
    logic [XY_W-1:0]    x_in;
    logic [XY_W-1:0]    y_in;
    logic [ANGLE_W-1:0] z_in;
    logic               out_valid;
    logic               out_ready;
    logic               mode_out;
    logic [XY_W-1:0]    x_out;
    logic [XY_W-1:0]    y_out;
    logic [ANGLE_W-1:0] z_out;
    logic               flip_out;

    int n_checks = 0;
    int n_fail   = 0;

    cordic_quad_prerot #(
        .XY_W    (XY_W),
        .ANGLE_W (ANGLE_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode_in   (mode_in),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mode_out  (mode_out),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out),
        .flip_out  (flip_out)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Helpers (stimulus / reference only)
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sample(input logic m, input logic [15:0] x,
                                input logic [15:0] y, input logic [31:0] z);
        in_valid = 1'b1;
        mode_in  = m;
        x_in     = x;
        y_in     = y;
        z_in     = z;
        step();
        in_valid = 1'b0;
    endtask

    function automatic logic [15:0] sat_neg(input logic [15:0] v);
        int r;
        r = -int'($signed(v));
        if (r > 32767) r = 32767;
        return r[15:0];
    endfunction

    // Reference: fold by value ranges, z + pi as modular addition.
    function automatic exp_t model(input logic m, input logic [15:0] x,
                                   input logic [15:0] y, input logic [31:0] z);
        exp_t e;
        int   zi;
        logic f;
        zi = $signed(z);
        if (m) f = ($signed(x) < 0);
        else   f = (zi >= 1073741824) || (zi < -1073741824);
        e.mode = m;
        e.flip = f;
        e.x    = f ? sat_neg(x) : x;
        e.y    = f ? sat_neg(y) : y;
        e.z    = f ? z + 32'h8000_0000 : z;
        return e;
    endfunction

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mode_in   = 1'b0;
        x_in      = '0;
        y_in      = '0;
        z_in      = '0;
        #3;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_handshake: out_valid,in_ready got %b expected 00", {out_valid, in_ready});
        end
        n_checks++;
        if ({mode_out, flip_out, x_out, y_out, z_out} !== 66'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", {mode_out, flip_out, x_out, y_out, z_out});
        end
        step();
        step();
        rst_n = 1'b1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_ready: in_ready got %b expected 0 before first edge", in_ready);
        end
        step();
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_first_edge: in_ready,out_valid got %b expected 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_rot_nofold();
        drive_sample(1'b0, 16'h4000, 16'h0000, 32'h2000_0000);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rot_nofold_latency: out_valid got %b expected 1", out_valid);
        end
        n_checks++;
        if ({mode_out, flip_out, x_out, y_out, z_out} !== {1'b0, 1'b0, 16'h4000, 16'h0000, 32'h2000_0000}) begin
            n_fail++;
            $display("FAIL rot_nofold_data: got %h expected %h", {mode_out, flip_out, x_out, y_out, z_out},
                     {1'b0, 1'b0, 16'h4000, 16'h0000, 32'h2000_0000});
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rot_nofold_drain: out_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_rot_fold();
        drive_sample(1'b0, 16'h4000, 16'h1000, 32'h6000_0000);
        n_checks++;
        if ({out_valid, mode_out, flip_out, x_out, y_out, z_out} !== {1'b1, 1'b0, 1'b1, 16'hC000, 16'hF000, 32'hE000_0000}) begin
            n_fail++;
            $display("FAIL rot_fold: got %h expected %h", {out_valid, mode_out, flip_out, x_out, y_out, z_out},
                     {1'b1, 1'b0, 1'b1, 16'hC000, 16'hF000, 32'hE000_0000});
        end
        // Exactly -pi/2 stays unfolded.
        drive_sample(1'b0, 16'h1234, 16'h0001, 32'hC000_0000);
        n_checks++;
        if ({out_valid, flip_out, x_out, y_out, z_out} !== {1'b1, 1'b0, 16'h1234, 16'h0001, 32'hC000_0000}) begin
            n_fail++;
            $display("FAIL rot_minus_half_pi: got %h expected %h", {out_valid, flip_out, x_out, y_out, z_out},
                     {1'b1, 1'b0, 16'h1234, 16'h0001, 32'hC000_0000});
        end
        // Just below -pi/2 folds: -pi/2 - 1 LSB + pi = pi/2 - 1 LSB.
        drive_sample(1'b0, 16'h0010, 16'hFFF0, 32'hBFFF_FFFF);
        n_checks++;
        if ({flip_out, x_out, y_out, z_out} !== {1'b1, 16'hFFF0, 16'h0010, 32'h3FFF_FFFF}) begin
            n_fail++;
            $display("FAIL rot_below_minus_half_pi: got %h expected %h", {flip_out, x_out, y_out, z_out},
                     {1'b1, 16'hFFF0, 16'h0010, 32'h3FFF_FFFF});
        end
        // Negative x in rotation mode is not a fold condition.
        drive_sample(1'b0, 16'h8000, 16'h0000, 32'h0000_0000);
        n_checks++;
        if ({flip_out, x_out, z_out} !== {1'b0, 16'h8000, 32'h0000_0000}) begin
            n_fail++;
            $display("FAIL rot_neg_x_nofold: got %h expected %h", {flip_out, x_out, z_out},
                     {1'b0, 16'h8000, 32'h0000_0000});
        end
        step();
    endtask

    task automatic test_vec_fold();
        drive_sample(1'b1, 16'h8000, 16'h0100, 32'h0000_0000);
        n_checks++;
        if ({out_valid, mode_out, flip_out, x_out, y_out, z_out} !== {1'b1, 1'b1, 1'b1, 16'h7FFF, 16'hFF00, 32'h8000_0000}) begin
            n_fail++;
            $display("FAIL vec_fold_sat: got %h expected %h", {out_valid, mode_out, flip_out, x_out, y_out, z_out},
                     {1'b1, 1'b1, 1'b1, 16'h7FFF, 16'hFF00, 32'h8000_0000});
        end
        // Positive x in vectoring mode ignores a far angle.
        drive_sample(1'b1, 16'h1000, 16'h8000, 32'h6000_0000);
        n_checks++;
        if ({mode_out, flip_out, x_out, y_out, z_out} !== {1'b1, 1'b0, 16'h1000, 16'h8000, 32'h6000_0000}) begin
            n_fail++;
            $display("FAIL vec_pos_x_nofold: got %h expected %h", {mode_out, flip_out, x_out, y_out, z_out},
                     {1'b1, 1'b0, 16'h1000, 16'h8000, 32'h6000_0000});
        end
        step();
    endtask

    task automatic test_backpressure();
        int           idx = 0;
        logic [15:0]  recv[$];
        for (int cyc = 0; cyc < 20 && recv.size() < 4; cyc++) begin
            out_ready = (cyc >= 3);
            in_valid  = (idx < 4);
            mode_in   = 1'b0;
            x_in      = 16'(idx + 1);
            y_in      = '0;
            z_in      = '0;
            if (cyc == 1 || cyc == 2) begin
                n_checks++;
                if ({out_valid, x_out} !== {1'b1, 16'h0001}) begin
                    n_fail++;
                    $display("FAIL bp_hold cyc%0d: valid,x_out got %h expected 10001", cyc, {out_valid, x_out});
                end
            end
            if (cyc == 2) begin
                n_checks++;
                if (in_ready !== 1'b0 || idx != 2) begin
                    n_fail++;
                    $display("FAIL bp_ready_drop: in_ready %b after %0d accepted, expected 0 after 2", in_ready, idx);
                end
            end
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) recv.push_back(x_out);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (recv.size() != 4) begin
            n_fail++;
            $display("FAIL bp_count: got %0d outputs expected 4", recv.size());
        end
        for (int k = 0; k < recv.size(); k++) begin
            n_checks++;
            if (recv[k] !== 16'(k + 1)) begin
                n_fail++;
                $display("FAIL bp_order[%0d]: got %h expected %h", k, recv[k], 16'(k + 1));
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        exp_t exp_q[$];
        exp_t got;
        int   idx    = 0;
        int   nrecv  = 0;
        int   drops  = 0;
        int   bad    = 0;
        int   cycles = 0;
        int   xv, yv;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 300 && nrecv < 100; cyc++) begin
            xv       = idx * 700 - 30000;
            yv       = 1000 - idx * 331;
            in_valid = (idx < 100);
            mode_in  = idx[0];
            x_in     = xv[15:0];
            y_in     = yv[15:0];
            z_in     = idx * 32'h0A3D_70A3;
            if (in_ready !== 1'b1) drops++;
            if (out_valid && out_ready) begin
                got = {mode_out, flip_out, x_out, y_out, z_out};
                if (exp_q.size() == 0 || got !== exp_q[0]) begin
                    bad++;
                    $display("FAIL b2b_sample[%0d]: got %h expected %h", nrecv, got,
                             (exp_q.size() != 0) ? exp_q[0] : exp_t'(0));
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                nrecv++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(mode_in, x_in, y_in, z_in));
                idx++;
            end
            step();
            cycles = cyc + 1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL b2b_data: %0d samples wrong, expected 0", bad);
        end
        n_checks++;
        if (nrecv != 100 || cycles != 101) begin
            n_fail++;
            $display("FAIL b2b_throughput: %0d outputs in %0d cycles, expected 100 in 101", nrecv, cycles);
        end
        n_checks++;
        if (drops != 0) begin
            n_fail++;
            $display("FAIL b2b_in_ready: low in %0d cycles, expected 0", drops);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        drive_sample(1'b0, 16'h0111, 16'h0000, 32'h0000_0000);
        drive_sample(1'b0, 16'h0222, 16'h0000, 32'h0000_0000);
        in_valid = 1'b1;
        x_in     = 16'h0333;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_mid_full: in_ready,out_valid got %b expected 01", {in_ready, out_valid});
        end
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready, x_out} !== {1'b0, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL rst_mid_async: valid,ready,x_out got %h expected 00000", {out_valid, in_ready, x_out});
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_mid_release: in_ready,out_valid got %b expected 10", {in_ready, out_valid});
        end
        out_ready = 1'b1;
        drive_sample(1'b0, 16'h0ABC, 16'h0000, 32'h0000_0000);
        n_checks++;
        if ({out_valid, x_out} !== {1'b1, 16'h0ABC}) begin
            n_fail++;
            $display("FAIL rst_mid_first: valid,x_out got %h expected 10abc", {out_valid, x_out});
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_no_dup: out_valid got %b expected 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_rot_nofold();
        test_rot_fold();
        test_vec_fold();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
